// File: rtl/ahfp_add_mc.sv
// Multi-cycle IEEE-754 single-precision adder with start/done handshake.
// Truncating, denormals flushed to zero, NaN/inf handled as specials.
module ahfp_add_mc (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [23:0] ml_q, ml_d, ms_q, ms_d;
    logic [7:0]  el_q, el_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic [24:0] m_q, m_d;
    logic [8:0]  e_q, e_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_big;
    logic [7:0]  e_big, e_small, dsh;
    logic [23:0] m_big, m_small, ms_al;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [8:0]  e_inc;
    logic [31:0] pack_shr, pack_keep;

    assign sa      = a_q[31];
    assign sb      = b_q[31];
    assign ea      = a_q[30:23];
    assign eb      = b_q[30:23];
    assign ma      = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    assign mb      = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    assign a_big   = (ea > eb) || ((ea == eb) && (ma >= mb));
    assign e_big   = a_big ? ea : eb;
    assign e_small = a_big ? eb : ea;
    assign m_big   = a_big ? ma : mb;
    assign m_small = a_big ? mb : ma;
    assign dsh     = e_big - e_small;
    assign ms_al   = (dsh >= 8'd24) ? 24'd0 : (m_small >> dsh);

    assign nan_a   = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign nan_b   = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign inf_a   = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign inf_b   = (eb == 8'hFF) && (b_q[22:0] == 23'd0);

    // Packing for the two finishing cases; exponent 255 saturates to inf.
    assign e_inc     = e_q + 9'd1;
    assign pack_shr  = (e_inc >= 9'd255) ? {sign_q, 8'hFF, 23'd0}
                                         : {sign_q, e_inc[7:0], m_q[23:1]};
    assign pack_keep = (e_q >= 9'd255) ? {sign_q, 8'hFF, 23'd0}
                                       : {sign_q, e_q[7:0], m_q[22:0]};

    // Next-state and datapath: one FSM step per enabled cycle.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        ml_d       = ml_q;
        ms_d       = ms_q;
        el_d       = el_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        m_d        = m_q;
        e_d        = e_q;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = dataa;
                    b_d     = datab;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                ml_d   = m_big;
                ms_d   = ms_al;
                el_d   = e_big;
                sign_d = a_big ? sa : sb;
                sub_d  = sa ^ sb;
                spec_d = (ea == 8'hFF) || (eb == 8'hFF);
                if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
                    spec_res_d = 32'h7FC0_0000;
                else if (inf_a)
                    spec_res_d = a_q;
                else
                    spec_res_d = b_q;
                state_d = ADD;
            end
            ADD: begin
                m_d     = sub_q ? ({1'b0, ml_q} - {1'b0, ms_q})
                                : ({1'b0, ml_q} + {1'b0, ms_q});
                e_d     = {1'b0, el_q};
                state_d = NORM;
            end
            NORM: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (spec_q)
                    result_d = spec_res_q;
                else if (m_q == 25'd0)
                    result_d = 32'h0;
                else if (m_q[24])
                    result_d = pack_shr;
                else if (m_q[23])
                    result_d = pack_keep;
                else if (e_q == 9'd1)
                    result_d = 32'h0;
                else begin
                    m_d     = {m_q[23:0], 1'b0};
                    e_d     = e_q - 9'd1;
                    state_d = NORM;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset wins over clk_en, clk_en low freezes all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            ml_q       <= 24'h0;
            ms_q       <= 24'h0;
            el_q       <= 8'h0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'h0;
            m_q        <= 25'h0;
            e_q        <= 9'h0;
            result_q   <= 32'h0;
            done_q     <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ml_q       <= ml_d;
            ms_q       <= ms_d;
            el_q       <= el_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            m_q        <= m_d;
            e_q        <= e_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ahfp_add_mc.sv
// Directed and randomized bench for ahfp_add_mc.
// Includes an independent truncating reference and clk_en stretching.
module tb_ahfp_add_mc;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    int errs;
    int checks;

    ahfp_add_mc dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Truncating reference: returns sum and number of normalize shifts.
    task automatic ref_add(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output int k);
        logic [7:0]  xa, xb;
        logic [22:0] fa, fb;
        logic [23:0] ma, mb, ml, ms;
        logic        sl, ss;
        int          el, es, d;
        logic [31:0] m, e;
        k  = 0;
        xa = a[30:23];
        xb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        if (xa == 8'hFF || xb == 8'hFF) begin
            if ((xa == 8'hFF && fa != 0) || (xb == 8'hFF && fb != 0) ||
                (xa == 8'hFF && xb == 8'hFF && a[31] != b[31]))
                r = 32'h7FC00000;
            else if (xa == 8'hFF)
                r = a;
            else
                r = b;
            return;
        end
        ma = (xa == 0) ? 24'd0 : {1'b1, fa};
        mb = (xb == 0) ? 24'd0 : {1'b1, fb};
        if ({xa, ma} >= {xb, mb}) begin
            el = xa; es = xb; ml = ma; ms = mb; sl = a[31]; ss = b[31];
        end else begin
            el = xb; es = xa; ml = mb; ms = ma; sl = b[31]; ss = a[31];
        end
        d  = el - es;
        ms = (d >= 24) ? 24'd0 : (ms >> d);
        m  = (sl == ss) ? ({8'd0, ml} + {8'd0, ms}) : ({8'd0, ml} - {8'd0, ms});
        e  = el;
        if (m == 0) begin
            r = 32'h0;
            return;
        end
        while (m < 32'h0080_0000) begin
            if (e == 1) begin
                r = 32'h0;
                return;
            end
            m = m << 1;
            e = e - 1;
            k++;
        end
        if (m >= 32'h0100_0000) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) r = {sl, 8'hFF, 23'd0};
        else          r = {sl, e[7:0], m[22:0]};
    endtask

    // One operation: start in cycle 0, count enabled cycles to done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_cyc,
                          input string tag, input bit rnd_en, input bit b2b);
        int  n;
        int  got;
        bit  en;
        clk_en = 1'b1;
        start  = 1'b1;
        dataa  = a;
        datab  = b;
        tick();
        start = 1'b0;
        n     = 1;
        got   = -1;
        for (int i = 0; i < 300 && got < 0; i++) begin
            if (done) got = n;
            else begin
                if (rnd_en) clk_en = ($urandom_range(0, 2) != 0);
                en = clk_en;
                tick();
                if (en) n++;
            end
        end
        chk($sformatf("%s cyc", tag), got, exp_cyc);
        chk($sformatf("%s res %h+%h", tag, a, b), result, exp_r);
        if (!b2b) begin
            clk_en = 1'b1;
            tick();
            chk($sformatf("%s done_drop", tag), {31'd0, done}, 32'd0);
            chk($sformatf("%s hold", tag), result, exp_r);
        end
    endtask

    logic [31:0] va [13];
    logic [31:0] vb [13];
    logic [31:0] vr [13];
    int          vc [13];

    initial begin
        int          n;
        int          ndone;
        int          first;
        int          k;
        logic [31:0] a, b, r, t;

        errs   = 0;
        checks = 0;
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 1'b0;
        dataa  = 32'h0;
        datab  = 32'h0;
        tick();
        tick();
        chk("rst result", result, 32'h0);
        chk("rst done", {31'd0, done}, 32'd0);
        reset  = 1'b0;
        clk_en = 1'b1;
        tick();

        va[0]  = 32'h3F800000; vb[0]  = 32'h3F800000; vr[0]  = 32'h40000000; vc[0]  = 4;
        va[1]  = 32'h3FC00000; vb[1]  = 32'hBF800000; vr[1]  = 32'h3F000000; vc[1]  = 5;
        va[2]  = 32'h3F800000; vb[2]  = 32'hBF800000; vr[2]  = 32'h00000000; vc[2]  = 4;
        va[3]  = 32'h7F7FFFFF; vb[3]  = 32'h7F7FFFFF; vr[3]  = 32'h7F800000; vc[3]  = 4;
        va[4]  = 32'h3F800000; vb[4]  = 32'h33800000; vr[4]  = 32'h3F800000; vc[4]  = 4;
        va[5]  = 32'h7F800000; vb[5]  = 32'hFF800000; vr[5]  = 32'h7FC00000; vc[5]  = 4;
        va[6]  = 32'h7FC00001; vb[6]  = 32'h3F800000; vr[6]  = 32'h7FC00000; vc[6]  = 4;
        va[7]  = 32'hFF800000; vb[7]  = 32'h3F800000; vr[7]  = 32'hFF800000; vc[7]  = 4;
        va[8]  = 32'h00800001; vb[8]  = 32'h80800000; vr[8]  = 32'h00000000; vc[8]  = 4;
        va[9]  = 32'h01400000; vb[9]  = 32'h81000000; vr[9]  = 32'h00800000; vc[9]  = 5;
        va[10] = 32'h00000001; vb[10] = 32'h3F800000; vr[10] = 32'h3F800000; vc[10] = 4;
        va[11] = 32'h3F800000; vb[11] = 32'h34000000; vr[11] = 32'h3F800001; vc[11] = 4;
        va[12] = 32'h3F800001; vb[12] = 32'hBF800000; vr[12] = 32'h34000000; vc[12] = 27;

        for (int i = 0; i < 13; i++)
            run_op(va[i], vb[i], vr[i], vc[i], $sformatf("dir%0d", i), 1'b0, 1'b0);

        // Second start in cycle 2 must not disturb the running op.
        start = 1'b1; dataa = 32'h3F800000; datab = 32'h3F800000;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; dataa = 32'h40400000; datab = 32'h40400000;
        tick();
        start = 1'b0;
        n = 3; ndone = 0; first = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = n;
            end
            tick();
            n++;
        end
        chk("ign ndone", ndone, 1);
        chk("ign cyc", first, 4);
        chk("ign res", result, 32'h40000000);

        // Reset in cycle 2 (with clk_en low) aborts the op.
        start = 1'b1; dataa = 32'h3FC00000; datab = 32'h3FC00000;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1; clk_en = 1'b0;
        tick();
        reset = 1'b0; clk_en = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("rst2 ndone", ndone, 0);
        chk("rst2 res", result, 32'h0);

        // Randomized against the reference, with clk_en toggling.
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            t = $urandom;
            case ($urandom_range(0, 4))
                0: b = t;
                1: b = {~a[31], a[30:0] ^ {24'd0, t[7:0]}};
                2: b = {t[31], a[30:23], t[22:0]};
                3: b = {t[31], 8'hFF, t[0] ? 23'd0 : t[22:0]};
                default: b = {t[31], 8'd0, t[22:0]};
            endcase
            if (i % 2 == 1) begin
                r = a; a = b; b = r;
            end
            ref_add(a, b, r, k);
            run_op(a, b, r, 4 + k, $sformatf("rnd%0d", i), 1'b1,
                   ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
